// File: rtl/dmme_ctrl.sv
// rtl/dmme_ctrl.sv - job controller feeding a skewed 2x2 operand schedule to a DMME engine
//
// Optional feature macro: DMME_CTRL_TIMEOUT_EN (WAIT gives up after TIMEOUT_CYC cycles).
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   start, abort                job request (IDLE only) and synchronous cancel
//   mode_in, mask_in            0=DENDEN / 1=SPADEN, masks {m11_1,m21_1,m11_2,m21_2}
//   op_valid, op_ready          operand-beat handshake; op_a, op_b carry one beat
//   busy                        high outside IDLE
//   eng_clr, eng_en, eng_mode   engine clear pulse, enable and latched mode
//   eng_mask                    latched masks
//   eng_ain1..eng_bin2          skewed operand feed
//   eng_done, eng_cout          engine completion flag and results {c12_1,c12_2,c22_1,c22_2}
//   res_valid, res_ready        result handshake; res_c results, res_err timeout flag
module dmme_ctrl #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic         mode_in,
    input  logic [15:0]  mask_in,
    input  logic         op_valid,
    output logic         op_ready,
    input  logic [63:0]  op_a,
    input  logic [63:0]  op_b,
    output logic         busy,
    output logic         eng_clr,
    output logic         eng_en,
    output logic         eng_mode,
    output logic [15:0]  eng_mask,
    output logic [63:0]  eng_ain1,
    output logic [63:0]  eng_bin1,
    output logic [63:0]  eng_ain2,
    output logic [63:0]  eng_bin2,
    input  logic         eng_done,
    input  logic [127:0] eng_cout,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [127:0] res_c,
    output logic         res_err
);

    typedef enum logic [2:0] {IDLE, LOAD, FEED, WAIT, RESULT} state_t;

    state_t      state;
    // Slot order: 0=A1_0/B1_0, 1=A1_1/B1_1, 2=A2_0/B2_0, 3=A2_1/B2_1
    logic [63:0] a_slot [4];
    logic [63:0] b_slot [4];
    logic [1:0]  beat_cnt;
    logic [1:0]  feed_cnt;
    logic        done_seen;
    logic [1:0]  slot_idx;
    logic        last_beat;

`ifdef DMME_CTRL_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0] to_cnt;
`else
    localparam int TIMEOUT_UNUSED = TIMEOUT_CYC;
    assign res_err = 1'b0;
`endif

    assign busy = (state != IDLE);

    // SPADEN beats land in the *_0 slots only, so its second beat goes to slot 2.
    always_comb begin
        slot_idx  = eng_mode ? {beat_cnt[0], 1'b0} : beat_cnt;
        last_beat = eng_mode ? (beat_cnt == 2'd1) : (beat_cnt == 2'd3);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op_ready  <= 1'b0;
            eng_clr   <= 1'b0;
            eng_en    <= 1'b0;
            eng_mode  <= 1'b0;
            eng_mask  <= '0;
            eng_ain1  <= '0;
            eng_bin1  <= '0;
            eng_ain2  <= '0;
            eng_bin2  <= '0;
            res_valid <= 1'b0;
            res_c     <= '0;
            beat_cnt  <= '0;
            feed_cnt  <= '0;
            done_seen <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                a_slot[i] <= '0;
                b_slot[i] <= '0;
            end
`ifdef DMME_CTRL_TIMEOUT_EN
            res_err   <= 1'b0;
            to_cnt    <= '0;
`endif
        end else begin
            eng_clr <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                op_ready  <= 1'b0;
                eng_en    <= 1'b0;
                eng_ain1  <= '0;
                eng_bin1  <= '0;
                eng_ain2  <= '0;
                eng_bin2  <= '0;
                res_valid <= 1'b0;
                done_seen <= 1'b0;
`ifdef DMME_CTRL_TIMEOUT_EN
                res_err   <= 1'b0;
                to_cnt    <= '0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state     <= LOAD;
                            eng_mode  <= mode_in;
                            eng_mask  <= mask_in;
                            eng_clr   <= 1'b1;
                            op_ready  <= 1'b1;
                            beat_cnt  <= '0;
                            done_seen <= 1'b0;
                            // Unloaded slots must read as zero (SPADEN *_1 slots).
                            for (int i = 0; i < 4; i++) begin
                                a_slot[i] <= '0;
                                b_slot[i] <= '0;
                            end
                        end
                    end
                    LOAD: begin
                        if (op_valid) begin
                            a_slot[slot_idx] <= op_a;
                            b_slot[slot_idx] <= op_b;
                            beat_cnt         <= beat_cnt + 2'd1;
                            if (last_beat) begin
                                // Slot 0 is always loaded by the first beat, so F1 can be
                                // presented straight from storage here.
                                state    <= FEED;
                                op_ready <= 1'b0;
                                eng_en   <= 1'b1;
                                feed_cnt <= '0;
                                eng_ain1 <= a_slot[0];
                                eng_bin1 <= b_slot[0];
                                eng_ain2 <= '0;
                                eng_bin2 <= '0;
                            end
                        end
                    end
                    FEED: begin
                        if (eng_done) begin
                            done_seen <= 1'b1;
                        end
                        feed_cnt <= feed_cnt + 2'd1;
                        // Outputs are registered: each step loads the next F-cycle values.
                        case (feed_cnt)
                            2'd0: begin
                                eng_ain1 <= a_slot[1];
                                eng_bin1 <= b_slot[1];
                                eng_ain2 <= a_slot[2];
                                eng_bin2 <= b_slot[2];
                            end
                            2'd1: begin
                                eng_ain1 <= '0;
                                eng_bin1 <= '0;
                                eng_ain2 <= a_slot[3];
                                eng_bin2 <= b_slot[3];
                            end
                            2'd2: begin
                                eng_ain1 <= '0;
                                eng_bin1 <= '0;
                                eng_ain2 <= '0;
                                eng_bin2 <= '0;
                            end
                            default: begin
                                state <= WAIT;
`ifdef DMME_CTRL_TIMEOUT_EN
                                to_cnt <= '0;
`endif
                            end
                        endcase
                    end
                    WAIT: begin
                        if (eng_done || done_seen) begin
                            state     <= RESULT;
                            res_c     <= eng_cout;
                            res_valid <= 1'b1;
                            eng_en    <= 1'b0;
                            done_seen <= 1'b0;
`ifdef DMME_CTRL_TIMEOUT_EN
                            res_err   <= 1'b0;
                        end else if (to_cnt == TO_LAST) begin
                            state     <= RESULT;
                            res_c     <= '0;
                            res_err   <= 1'b1;
                            res_valid <= 1'b1;
                            eng_en    <= 1'b0;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
`endif
                        end
                    end
                    RESULT: begin
                        if (res_ready) begin
                            state     <= IDLE;
                            res_valid <= 1'b0;
`ifdef DMME_CTRL_TIMEOUT_EN
                            res_err   <= 1'b0;
`endif
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dmme_ctrl.sv
// tb/tb_dmme_ctrl.sv - randomized self-checking bench for dmme_ctrl against a slot/schedule model
module tb_dmme_ctrl;

`ifdef DMME_CTRL_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 64;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0, abort = 1'b0, mode_in = 1'b0;
    logic [15:0]  mask_in = '0;
    logic         op_valid = 1'b0, op_ready;
    logic [63:0]  op_a = '0, op_b = '0;
    logic         busy, eng_clr, eng_en, eng_mode;
    logic [15:0]  eng_mask;
    logic [63:0]  eng_ain1, eng_bin1, eng_ain2, eng_bin2;
    logic         eng_done = 1'b0;
    logic [127:0] eng_cout = '0;
    logic         res_valid, res_ready = 1'b0, res_err;
    logic [127:0] res_c;

    dmme_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode_in(mode_in),
        .mask_in(mask_in), .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a),
        .op_b(op_b), .busy(busy), .eng_clr(eng_clr), .eng_en(eng_en),
        .eng_mode(eng_mode), .eng_mask(eng_mask), .eng_ain1(eng_ain1),
        .eng_bin1(eng_bin1), .eng_ain2(eng_ain2), .eng_bin2(eng_bin2),
        .eng_done(eng_done), .eng_cout(eng_cout), .res_valid(res_valid),
        .res_ready(res_ready), .res_c(res_c), .res_err(res_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [63:0] job_a [4];
    logic [63:0] job_b [4];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_ports_zero(input string tag);
        check({tag, "_ain1"}, eng_ain1, 0);
        check({tag, "_bin1"}, eng_bin1, 0);
        check({tag, "_ain2"}, eng_ain2, 0);
        check({tag, "_bin2"}, eng_bin2, 0);
    endtask

    // kind: 0 done in WAIT after wd cycles, 1 done during FEED, 2 abort at F2,
    //       3 reset mid-WAIT, 4 timeout (timeout build only)
    task automatic run_job(input logic mode, input logic [15:0] mask, input logic [127:0] cout,
                           input int kind, input int wd);
        logic [63:0]  sa [4];
        logic [63:0]  sb [4];
        logic [63:0]  ep [4][4];
        logic [127:0] exp_c;
        int           nb;
        nb = mode ? 2 : 4;
        for (int i = 0; i < 4; i++) begin
            sa[i] = '0;
            sb[i] = '0;
        end
        for (int k = 0; k < nb; k++) begin
            sa[mode ? 2 * k : k] = job_a[k];
            sb[mode ? 2 * k : k] = job_b[k];
        end
        // ep[f] = {ain1, bin1, ain2, bin2} during F(f+1)
        ep[0][0] = sa[0]; ep[0][1] = sb[0]; ep[0][2] = '0;    ep[0][3] = '0;
        ep[1][0] = sa[1]; ep[1][1] = sb[1]; ep[1][2] = sa[2]; ep[1][3] = sb[2];
        ep[2][0] = '0;    ep[2][1] = '0;    ep[2][2] = sa[3]; ep[2][3] = sb[3];
        ep[3][0] = '0;    ep[3][1] = '0;    ep[3][2] = '0;    ep[3][3] = '0;

        start = 1'b1; mode_in = mode; mask_in = mask; eng_cout = cout;
        tick;
        check("load_busy", busy, 1);
        check("load_clr", eng_clr, 1);
        check("load_op_ready", op_ready, 1);
        check("load_mode", eng_mode, mode);
        check("load_mask", eng_mask, mask);
        mode_in = ~mode; mask_in = ~mask;
        tick;
        start = 1'b0;
        check("busy_start_mode", eng_mode, mode);
        check("busy_start_mask", eng_mask, mask);
        check("clr_once", eng_clr, 0);
        for (int k = 0; k < nb; k++) begin
            repeat ($urandom_range(0, 2)) begin
                tick;
                check("gap_op_ready", op_ready, 1);
            end
            op_valid = 1'b1; op_a = job_a[k]; op_b = job_b[k];
            tick;
            op_valid = 1'b0; op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom};
            check("beat_op_ready", op_ready, (k < nb - 1) ? 1 : 0);
        end
        for (int f = 0; f < 4; f++) begin
            check("feed_ain1", eng_ain1, ep[f][0]);
            check("feed_bin1", eng_bin1, ep[f][1]);
            check("feed_ain2", eng_ain2, ep[f][2]);
            check("feed_bin2", eng_bin2, ep[f][3]);
            check("feed_en", eng_en, 1);
            check("feed_mask", eng_mask, mask);
            if (f == 1 && kind == 2) begin
                abort = 1'b1;
                tick;
                abort = 1'b0;
                check("abort_busy", busy, 0);
                check("abort_en", eng_en, 0);
                check_ports_zero("abort");
                eng_done = 1'b1;
                repeat (3) begin
                    tick;
                    check("abort_res_valid", res_valid, 0);
                end
                eng_done = 1'b0;
                return;
            end
            if (f == 1 && kind == 1) eng_done = 1'b1;
            tick;
            eng_done = 1'b0;
        end
        check_ports_zero("wait");
        check("wait_en", eng_en, 1);
        check("wait_res_valid", res_valid, 0);
        exp_c = cout;
        if (kind == 3) begin
            #3 rst = 1'b1;
            #1;
            check("rst_busy", busy, 0);
            check("rst_en", eng_en, 0);
            check("rst_mask", eng_mask, 0);
            @(posedge clk);
            #1 rst = 1'b0;
            repeat (2) begin
                tick;
                check("rst_res_valid", res_valid, 0);
                check("rst_idle", busy, 0);
            end
            return;
        end else if (kind == 0) begin
            repeat (wd) begin
                tick;
                check("wait_hold", res_valid, 0);
            end
            eng_done = 1'b1;
            tick;
            eng_done = 1'b0;
        end else if (kind == 4) begin
            repeat (TO - 1) begin
                tick;
                check("to_hold", res_valid, 0);
            end
            tick;
            exp_c = '0;
        end else begin
            tick;
        end
        eng_cout = {$urandom, $urandom, $urandom, $urandom};
        repeat ($urandom_range(1, 4)) begin
            check("res_valid", res_valid, 1);
            check("res_c", res_c, exp_c);
            check("res_err", res_err, (kind == 4) ? 1 : 0);
            check("res_mode", eng_mode, mode);
            tick;
        end
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        check("done_busy", busy, 0);
        check("done_res_valid", res_valid, 0);
    endtask

    initial begin
        #12;
        check("rst_async_busy", busy, 0);
        check("rst_async_op_ready", op_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        check("reset_res_valid", res_valid, 0);
        check("reset_res_c", res_c, 0);
        check("reset_en", eng_en, 0);
        check("reset_mode_mask", {eng_mode, eng_mask}, 0);
        check_ports_zero("reset");

        op_valid = 1'b1;
        repeat (3) begin
            tick;
            check("idle_op_valid_busy", busy, 0);
            check("idle_op_ready", op_ready, 0);
        end
        op_valid = 1'b0;
        start = 1'b1; abort = 1'b1;
        tick;
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", busy, 0);
        check("start_abort_clr", eng_clr, 0);

        job_a[0] = 64'h2345678923456789; job_b[0] = 64'h1111000011110000;
        job_a[1] = 64'h1111000011110000; job_b[1] = 64'h2345678923456789;
        job_a[2] = 64'h8765432187654321; job_b[2] = 64'h0000111100001111;
        job_a[3] = 64'h0000111100001111; job_b[3] = 64'h8765432187654321;
        run_job(1'b0, 16'h5555, 128'h00000001_00000002_00000003_00000004, 0, 2);

        job_a[1] = 64'h8765432187654321; job_b[1] = 64'h0000111100001111;
        run_job(1'b1, 16'hA3C5, 128'h0000000A_0000000B_0000000C_0000000D, 1, 0);

        run_job(1'b0, 16'h1234, 128'h55, 2, 0);
        run_job(1'b1, 16'h4321, 128'h66, 3, 0);
`ifdef DMME_CTRL_TIMEOUT_EN
        run_job(1'b0, 16'hFFFF, 128'h77, 4, 0);
`endif

        for (int j = 0; j < 24; j++) begin
            for (int k = 0; k < 4; k++) begin
                job_a[k] = {$urandom, $urandom};
                job_b[k] = {$urandom, $urandom};
            end
            run_job(1'($urandom_range(0, 1)), 16'($urandom),
                    {$urandom, $urandom, $urandom, $urandom},
`ifdef DMME_CTRL_TIMEOUT_EN
                    $urandom_range(0, 4),
`else
                    $urandom_range(0, 3),
`endif
                    $urandom_range(0, 5));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
